// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Shared constants for the up/down modulo counter family.
//             MODE_WRAP / MODE_SAT select the behaviour at the range ends
//             through the SATURATE parameter of updn_mod_counter.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int MODE_WRAP = 0;   // wrap to the opposite range end
    localparam int MODE_SAT  = 1;   // hold at the range end

endpackage : counter_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : tick_prescaler
//  Purpose  : Produces one tick every PRESCALE enabled cycles. The phase
//             counter only advances while en=1, so dropping en freezes the
//             phase instead of restarting it.
//  Ports    : clk     - rising-edge clock
//             reset   - synchronous active-high reset (phase -> 0)
//             en      - advance enable
//             restart - synchronous phase restart (phase -> 0)
//             tick    - combinational, high when en=1 on the last phase
//  Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    // PRESCALE=1 still uses a 1-bit phase register that stays at zero, so
    // the tick degenerates to en without a separate code path.
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_phase;
    logic          w_last;

    assign w_last = (r_phase == c_LAST);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_phase <= '0;
        end else if (en) begin
            r_phase <= w_last ? '0 : r_phase + CW'(1);
        end
    end

    assign tick = en && w_last;

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/updn_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : updn_mod_counter
//  Purpose  : Parameterised up/down modulo-MOD counter with prescaler,
//             synchronous clear/load, wrap or saturate at the range ends,
//             a one-cycle terminal-count pulse and a sticky overflow flag.
//  Ports    : clk      - rising-edge clock
//             reset    - synchronous active-high reset
//             en       - count enable (gates prescaler and step)
//             up       - 1 increment, 0 decrement
//             clear    - synchronous clear of count and prescaler
//             load     - synchronous parallel load of load_val (clamped)
//             load_val - load value, values >= MOD load MOD-1
//             ovf_clr  - clears the sticky ovf flag
//             count    - registered count, 0..MOD-1
//             tc       - registered terminal-count pulse
//             ovf      - registered sticky overflow/underflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module updn_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // The modulus may equal 2**WIDTH, so it needs WIDTH+1 bits.
    localparam logic [WIDTH:0]   c_MOD = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MOD - 1);
    localparam bit               c_SAT = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic             w_tick;
    logic             w_restart;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_term;
    logic             w_take;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_load_val;

    assign w_restart = clear || load;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Terminal detection falls out of the widened arithmetic: reaching MOD
    // on increment, or a borrow into the extra bit on decrement.
    assign w_inc    = {1'b0, r_count} + 1'b1;
    assign w_dec    = {1'b0, r_count} - 1'b1;
    assign w_at_top = (w_inc == c_MOD);
    assign w_at_bot = w_dec[WIDTH];
    assign w_term   = up ? w_at_top : w_at_bot;

    always_comb begin
        w_step_val = r_count;
        if (up) begin
            if (!w_at_top)  w_step_val = w_inc[WIDTH-1:0];
            else if (c_SAT) w_step_val = c_MAX;
            else            w_step_val = '0;
        end else begin
            if (!w_at_bot)  w_step_val = w_dec[WIDTH-1:0];
            else if (c_SAT) w_step_val = '0;
            else            w_step_val = c_MAX;
        end
    end

    assign w_load_val = ({1'b0, load_val} >= c_MOD) ? c_MAX : load_val;

    // A tick only counts when neither clear nor load claims the cycle.
    assign w_take = w_tick && !w_restart;

    always_ff @(posedge clk) begin
        if (reset)       r_count <= '0;
        else if (clear)  r_count <= '0;
        else if (load)   r_count <= w_load_val;
        else if (w_tick) r_count <= w_step_val;
    end

    always_ff @(posedge clk) begin
        if (reset) r_tc <= 1'b0;
        else       r_tc <= w_take && w_term;
    end

    // Setting wins over a simultaneous ovf_clr.
    always_ff @(posedge clk) begin
        if (reset)                  r_ovf <= 1'b0;
        else if (w_take && w_term)  r_ovf <= 1'b1;
        else if (ovf_clr)           r_ovf <= 1'b0;
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule : updn_mod_counter
`default_nettype wire
